// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment receive path.
package seg7_pkg;

  // Active-low segment patterns, bit6=a ... bit0=g.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // err_code bit positions
  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_MULTI   = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern to hex code decoder.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       legal,
  output logic       is_blank
);

  // Table lookup; anything outside the 16 glyphs and blank is illegal.
  always_comb begin
    code     = 4'h0;
    legal    = 1'b1;
    is_blank = 1'b0;
    case (seg)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_A:     code = 4'hA;
      SEG_B:     code = 4'hB;
      SEG_C:     code = 4'hC;
      SEG_D:     code = 4'hD;
      SEG_E:     code = 4'hE;
      SEG_F:     code = 4'hF;
      SEG_BLANK: begin
        legal    = 1'b0;
        is_blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and recovers per-digit codes.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4,
  parameter int IDX_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg,
  input  logic [NDIG-1:0]      an,
  input  logic                 clr_err,
  output logic [4*NDIG-1:0]    digits,
  output logic [NDIG-1:0]      vld,
  output logic [NDIG-1:0]      blank,
  output logic                 upd,
  output logic [IDX_W-1:0]     upd_idx,
  output logic [3:0]           upd_code,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam int SW    = 7 + NDIG;

  logic [6:0]            seg_s1, seg_s2;
  logic [NDIG-1:0]       an_s1, an_s2;
  logic [SW-1:0]         last_q;
  logic [CNT_W-1:0]      cnt_q;
  state_t                state_q;
  logic [NDIG-1:0][3:0]  dig_q;

  logic                  changed, none, multi, cap_go;
  logic [IDX_W-1:0]      sel_idx;
  logic [1:0]            err_set;
  logic [3:0]            dec_code;
  logic                  dec_legal, dec_blank;
  int                    n_low;

  assign digits = dig_q;

  seg7_pattern_decode u_dec (
    .seg      (seg_s2),
    .code     (dec_code),
    .legal    (dec_legal),
    .is_blank (dec_blank)
  );

  // Two-flop synchronizers, preset to the idle (all-off, no digit) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      an_s1  <= '1;
      an_s2  <= '1;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      an_s1  <= an;
      an_s2  <= an_s1;
    end
  end

  assign changed = ({seg_s2, an_s2} != last_q);

  // Stability counter: restarts on any change, and is held at zero in IDLE so
  // SETTLE always starts from a fresh count (also on digit switches with no gap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '1;
      cnt_q  <= '0;
    end else begin
      last_q <= {seg_s2, an_s2};
      if (changed || state_q == IDLE) cnt_q <= '0;
      else if (cnt_q != CNT_W'(STABLE_CYC)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Anode classification, capture qualifier and new error causes.
  always_comb begin
    n_low   = $countones(~an_s2);
    none    = (n_low == 0);
    multi   = (n_low > 1);
    sel_idx = '0;
    for (int i = 0; i < NDIG; i++)
      if (!an_s2[i]) sel_idx = IDX_W'(i);
    cap_go  = (state_q == SETTLE) && !none && !multi && !changed &&
              (cnt_q == CNT_W'(STABLE_CYC - 1));
    err_set              = 2'b00;
    err_set[ERR_MULTI]   = (state_q == IDLE || state_q == SETTLE) && multi;
    err_set[ERR_ILLEGAL] = cap_go && !dec_legal && !dec_blank;
  end

  // Scan FSM with registered capture outputs and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dig_q    <= '0;
      vld      <= '0;
      blank    <= '1;
      upd      <= 1'b0;
      upd_idx  <= '0;
      upd_code <= 4'h0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      upd      <= 1'b0;
      // a fresh cause in the same cycle as clr_err survives the clear
      err_code <= (clr_err ? 2'b00 : err_code) | err_set;
      err      <= (clr_err ? 1'b0 : err) | (|err_set);
      case (state_q)
        IDLE: begin
          if (multi)      state_q <= FAULT;
          else if (!none) state_q <= SETTLE;
        end
        SETTLE: begin
          if (none)       state_q <= IDLE;
          else if (multi) state_q <= FAULT;
          else if (cap_go) begin
            state_q  <= CAPTURE;
            upd      <= 1'b1;
            upd_idx  <= sel_idx;
            upd_code <= dec_legal ? dec_code : 4'h0;
            for (int i = 0; i < NDIG; i++) begin
              if (!an_s2[i]) begin
                if (dec_legal) dig_q[i] <= dec_code;
                vld[i]   <= dec_legal;
                blank[i] <= dec_blank;
              end
            end
          end
        end
        CAPTURE: state_q <= HOLD;
        HOLD:    if (changed) state_q <= IDLE;
        FAULT:   if (none) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized bench for seg7_scan_decoder with a glyph-table model.
module tb_seg7_scan_decoder;

  localparam int NDIG       = 4;
  localparam int STABLE_CYC = 4;
  localparam int IDX_W      = 2;
  // samples are taken #1 after each edge; the first edge after driving is sample 1
  localparam int LAT        = STABLE_CYC + 3;

  localparam logic [6:0] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clr_err = 1'b0;
  logic [6:0]          seg = 7'h7F;
  logic [NDIG-1:0]     an = '1;
  logic [4*NDIG-1:0]   digits;
  logic [NDIG-1:0]     vld, blank;
  logic                upd, err;
  logic [IDX_W-1:0]    upd_idx;
  logic [3:0]          upd_code;
  logic [1:0]          err_code;

  int checks = 0;
  int errors = 0;

  int               nupd, first_c;
  logic [IDX_W-1:0] got_idx;
  logic [3:0]       got_code;

  int        m_dig   [NDIG];
  bit        m_vld   [NDIG];
  bit        m_blank [NDIG];
  logic [1:0] m_err;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .clr_err(clr_err),
    .digits(digits), .vld(vld), .blank(blank), .upd(upd), .upd_idx(upd_idx),
    .upd_code(upd_code), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // glyph index of a pattern, -1 if not a hex glyph
  function automatic int ref_code(input logic [6:0] s);
    int r = -1;
    for (int v = 0; v < 16; v++) if (PAT[v] == s) r = v;
    return r;
  endfunction

  function automatic logic [31:0] exp_digits();
    logic [31:0] r = '0;
    for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'(m_dig[i]);
    return r;
  endfunction

  function automatic logic [31:0] exp_vld();
    logic [31:0] r = '0;
    for (int i = 0; i < NDIG; i++) r[i] = m_vld[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_blank();
    logic [31:0] r = '0;
    for (int i = 0; i < NDIG; i++) r[i] = m_blank[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDIG; i++) begin
      m_dig[i] = 0; m_vld[i] = 1'b0; m_blank[i] = 1'b1;
    end
    m_err = 2'b00;
  endtask

  // drive pins, then watch n cycles for capture strobes
  task automatic drive(input logic [6:0] s, input logic [NDIG-1:0] a, input int n);
    @(posedge clk); #1;
    seg = s; an = a;
    nupd = 0; first_c = 0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (upd === 1'b1) begin
        nupd++;
        if (first_c == 0) first_c = c;
        got_idx = upd_idx; got_code = upd_code;
      end
    end
  endtask

  task automatic gap(input string tag, input int n);
    drive(7'h7F, '1, n);
    check({tag, "_gap_upd"}, nupd, 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_digits"},   digits,   exp_digits());
    check({tag, "_vld"},      vld,      exp_vld());
    check({tag, "_blank"},    blank,    exp_blank());
    check({tag, "_err_code"}, err_code, m_err);
    check({tag, "_err"},      err,      |m_err);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_digits"},   digits,   0);
    check({tag, "_vld"},      vld,      0);
    check({tag, "_blank"},    blank,    32'hF);
    check({tag, "_upd"},      upd,      0);
    check({tag, "_upd_idx"},  upd_idx,  0);
    check({tag, "_upd_code"}, upd_code, 0);
    check({tag, "_err"},      err,      0);
    check({tag, "_err_code"}, err_code, 0);
  endtask

  // hold one pattern on digit d long enough to be captured
  task automatic cap_step(input string tag, input logic [6:0] s, input int d,
                          input int n, input bit timed, input int gap_n);
    logic [NDIG-1:0] a = '1;
    int v;
    a[d] = 1'b0;
    drive(s, a, n);
    v = ref_code(s);
    check({tag, "_nupd"}, nupd, 1);
    if (timed) check({tag, "_lat"}, first_c, LAT);
    check({tag, "_idx"},  got_idx,  d);
    check({tag, "_code"}, got_code, (v >= 0) ? v : 0);
    if (v >= 0) begin
      m_dig[d] = v; m_vld[d] = 1'b1; m_blank[d] = 1'b0;
    end else if (s == 7'h7F) begin
      m_vld[d] = 1'b0; m_blank[d] = 1'b1;
    end else begin
      m_vld[d] = 1'b0; m_blank[d] = 1'b0; m_err[0] = 1'b1;
    end
    if (gap_n > 0) gap(tag, gap_n);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    m_err = 2'b00;
  endtask

  initial begin
    logic [6:0]      s;
    logic [NDIG-1:0] a;
    int              kind, d;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst_n = 1'b1;
    drive(7'h7F, '1, 20);
    check("rst_idle_upd", nupd, 0);

    // single digit capture with latency check
    cap_step("d0_2", PAT[2], 0, 10, 1'b1, 2);
    check_state("d0_2");

    // scan all four digits with 1, A, b, F
    cap_step("scan0", PAT[1],  0, 8, 1'b1, 2);
    cap_step("scan1", PAT[10], 1, 8, 1'b1, 2);
    cap_step("scan2", PAT[11], 2, 8, 1'b1, 2);
    cap_step("scan3", PAT[15], 3, 8, 1'b1, 2);
    check("scan_digits", digits, 32'hFBA1);
    check_state("scan");

    // glitching segments never settle, then a steady 1 is captured once
    for (int g = 0; g < 10; g++) begin
      drive((g % 2) ? PAT[0] : PAT[8], 4'b1101, 1);
      check("glitch_upd", nupd, 0);
    end
    cap_step("glitch_end", PAT[1], 1, 10, 1'b1, 2);
    check_state("glitch");

    // digit switch without an all-high gap
    cap_step("nogap_a", PAT[7], 2, 10, 1'b1, 0);
    cap_step("nogap_b", PAT[9], 3, 10, 1'b0, 2);
    check_state("nogap");

    // illegal pattern, then clear
    cap_step("illegal", 7'b1111110, 2, 10, 1'b1, 2);
    check_state("illegal");
    pulse_clr();
    check_state("clr");

    // blank capture
    cap_step("blank", 7'h7F, 0, 10, 1'b1, 2);
    check_state("blank");

    // two anodes low
    drive(PAT[3], 4'b0011, 10);
    check("multi_upd", nupd, 0);
    m_err[1] = 1'b1;
    gap("multi", 2);
    check_state("multi");

    // randomized segments
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      d    = $urandom_range(0, NDIG - 1);
      if (kind <= 5) begin
        cap_step("rnd_legal", PAT[$urandom_range(0, 15)], d, $urandom_range(8, 14), 1'b1, $urandom_range(2, 4));
      end else if (kind == 6) begin
        cap_step("rnd_blank", 7'h7F, d, $urandom_range(8, 14), 1'b1, $urandom_range(2, 4));
      end else if (kind == 7) begin
        do s = 7'($urandom); while (ref_code(s) >= 0 || s == 7'h7F);
        cap_step("rnd_illegal", s, d, $urandom_range(8, 14), 1'b1, $urandom_range(2, 4));
      end else if (kind == 8) begin
        a = '1; a[d] = 1'b0;
        drive(PAT[$urandom_range(0, 15)], a, $urandom_range(1, 3));
        check("rnd_short_upd", nupd, 0);
        gap("rnd_short", $urandom_range(2, 4));
      end else begin
        do a = NDIG'($urandom); while ($countones(~a) < 2);
        drive(7'($urandom), a, $urandom_range(3, 8));
        check("rnd_multi_upd", nupd, 0);
        m_err[1] = 1'b1;
        gap("rnd_multi", $urandom_range(2, 4));
      end
      if ($urandom_range(0, 7) == 0) pulse_clr();
      check_state("rnd");
    end

    // reset asserted while settling on a legal pattern
    drive(PAT[5], 4'b1110, 4);
    check("midsettle_upd", nupd, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_reset_outs("midrst");
    @(posedge clk); #1;
    check_reset_outs("midrst_hold");
    rst_n = 1'b1;
    drive(7'h7F, '1, 10);
    check("midrst_after_upd", nupd, 0);
    check_state("midrst_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
